// File: rtl/slave_port_arbiter.sv
// Purpose : slave-side AHB stage. Arbitrates among masters addressing this slave, drives the winner's
//           address/control to the slave, forwards the data-phase owner's write data, and generates per-master HREADY.
// Latency : address path is 0-cycle (combinational mux). The data phase follows one accepted cycle later.
// Backpr. : i_shready=0 freezes all registered state. Losing requesters see o_mhready=0 until they are granted.
// Ports   : i_hclk/i_hreset (sync, active-high); i_mh* per-master AHB request inputs (packed [master][field]);
//           o_mhready per-master ready; o_sh* forwarded slave bus; i_shready slave HREADYOUT;
//           o_grant one-hot address-phase owner.
// Config  : SLV_ARB_ROUND_ROBIN_EN selects round-robin arbitration (search from last grant + 1).
//           When it is undefined, arbitration is fixed priority (lowest index wins) and there is no pointer.
module slave_port_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                                   i_hclk,
   input  logic                                   i_hreset,
   input  logic [NUM_MASTERS-1:0]                 i_mhsel,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_mhaddr,
   input  logic [NUM_MASTERS-1:0][1:0]            i_mhtrans,
   input  logic [NUM_MASTERS-1:0]                 i_mhwrite,
   input  logic [NUM_MASTERS-1:0][2:0]            i_mhsize,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_mhwdata,
   output logic [NUM_MASTERS-1:0]                 o_mhready,
   output logic                                   o_shsel,
   output logic [ADDR_WIDTH-1:0]                  o_shaddr,
   output logic [1:0]                             o_shtrans,
   output logic                                   o_shwrite,
   output logic [2:0]                             o_shsize,
   output logic [DATA_WIDTH-1:0]                  o_shwdata,
   input  logic                                   i_shready,
   output logic [NUM_MASTERS-1:0]                 o_grant
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   localparam logic [1:0] HT_IDLE = 2'd0;
   localparam logic [1:0] HT_BUSY = 2'd1;
   localparam logic [1:0] HT_SEQ  = 2'd3;

   typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  own_q, own_d;
   logic [IW-1:0]  dph_own_q, dph_own_d;
   logic           dph_vld_q, dph_vld_d;
`ifdef SLV_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [IW:0]    cand;
`endif

   logic [NUM_MASTERS-1:0] req;
   logic                   keep;
   logic                   win_vld;
   logic [IW-1:0]          win_idx;
   logic                   aown_vld;
   logic [IW-1:0]          aown_idx;

   // ---------------- state register ----------------
   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         state_q   <= S_IDLE;
         own_q     <= '0;
         dph_own_q <= '0;
         dph_vld_q <= 1'b0;
`ifdef SLV_ARB_ROUND_ROBIN_EN
         ptr_q     <= IW'(NUM_MASTERS - 1);
`endif
      end else begin
         state_q   <= state_d;
         own_q     <= own_d;
         dph_own_q <= dph_own_d;
         dph_vld_q <= dph_vld_d;
`ifdef SLV_ARB_ROUND_ROBIN_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   // ---------------- next-state / arbitration ----------------
   always_comb begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
         req[IW'(m)] = i_mhsel[IW'(m)] & i_mhtrans[IW'(m)][1];
      end

      // The owner keeps the slave through SEQ/BUSY beats of its burst.
      keep = (state_q == S_LOCK) && i_mhsel[own_q] &&
             ((i_mhtrans[own_q] == HT_SEQ) || (i_mhtrans[own_q] == HT_BUSY));

      win_vld = 1'b0;
      win_idx = '0;
`ifdef SLV_ARB_ROUND_ROBIN_EN
      // Scan from farthest to nearest after the pointer so the nearest requester wins.
      // One extra bit lets ptr+k exceed NUM_MASTERS before it wraps.
      cand = '0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NUM_MASTERS)) begin
            cand = cand - (IW+1)'(NUM_MASTERS);
         end
         if (req[cand[IW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = cand[IW-1:0];
         end
      end
`else
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         if (req[IW'(k)]) begin
            win_vld = 1'b1;
            win_idx = IW'(k);
         end
      end
`endif

      aown_vld = keep | win_vld;
      aown_idx = keep ? own_q : win_idx;

      state_d   = state_q;
      own_d     = own_q;
      dph_own_d = dph_own_q;
      dph_vld_d = dph_vld_q;
`ifdef SLV_ARB_ROUND_ROBIN_EN
      ptr_d     = ptr_q;
`endif
      if (i_shready) begin
         state_d   = aown_vld ? S_LOCK : S_IDLE;
         own_d     = aown_idx;
         dph_own_d = aown_idx;
         // BUSY/IDLE beats carry no data phase.
         dph_vld_d = aown_vld & i_mhtrans[aown_idx][1];
`ifdef SLV_ARB_ROUND_ROBIN_EN
         if (aown_vld) begin
            ptr_d = aown_idx;
         end
`endif
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      o_shsel   = 1'b0;
      o_shaddr  = '0;
      o_shtrans = HT_IDLE;
      o_shwrite = 1'b0;
      o_shsize  = '0;
      o_grant   = '0;
      if (aown_vld) begin
         o_shsel            = i_mhsel[aown_idx];
         o_shaddr           = i_mhaddr[aown_idx];
         o_shtrans          = i_mhtrans[aown_idx];
         o_shwrite          = i_mhwrite[aown_idx];
         o_shsize           = i_mhsize[aown_idx];
         o_grant[aown_idx]  = 1'b1;
      end

      o_shwdata = dph_vld_q ? i_mhwdata[dph_own_q] : '0;

      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (dph_vld_q && (dph_own_q == IW'(m))) begin
            o_mhready[IW'(m)] = i_shready;
         end else if (req[IW'(m)] && !(aown_vld && (aown_idx == IW'(m)))) begin
            o_mhready[IW'(m)] = 1'b0;   // losing requester holds its address phase
         end else if (aown_vld && (aown_idx == IW'(m))) begin
            o_mhready[IW'(m)] = i_shready;
         end else begin
            o_mhready[IW'(m)] = 1'b1;
         end
      end
   end

endmodule
